// File: rtl/audioport_pkg.sv
// Shared constants and types for the audioport blocks.
// Rate codes map to the mclk divider that produces the I2S bit clock.
package audioport_pkg;

    localparam logic [1:0] RATE_48000  = 2'b00;
    localparam logic [1:0] RATE_96000  = 2'b01;
    localparam logic [1:0] RATE_192000 = 2'b10;

    localparam int MCLK_DIV_48000  = 8;
    localparam int MCLK_DIV_96000  = 4;
    localparam int MCLK_DIV_192000 = 2;

    localparam int I2S_FRAME_BITS = 48;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        STOPPING
    } i2s_state_t;

    // Terminal count of the bit-clock divider; the unused code falls back to 48 kHz.
    function automatic logic [2:0] i2s_div_last(input logic [1:0] rate);
        case (rate)
            RATE_96000:  return 3'(MCLK_DIV_96000 - 1);
            RATE_192000: return 3'(MCLK_DIV_192000 - 1);
            default:     return 3'(MCLK_DIV_48000 - 1);
        endcase
    endfunction

endpackage

// File: rtl/i2s_unit.sv
// I2S serializer: buffers one stereo pair and streams it as a 48-bit frame,
// bit clock derived from mclk by the rate-dependent divider.
module i2s_unit
    import audioport_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_in,
    input  logic [1:0]  cfg_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out
);

    localparam int LAST_BIT = I2S_FRAME_BITS - 1;

    i2s_state_t  state;
    logic [2:0]  div_last;
    logic [2:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [47:0] in_buf;
    logic [46:0] frame_sr;

    logic bit_start;
    logic bit_end;
    logic frame_load;
    logic frame_end;
    logic ws_next;

    assign bit_start  = (div_cnt == 3'd0);
    assign bit_end    = (div_cnt == div_last);
    assign frame_load = bit_start && (bit_cnt == 6'd0);
    assign frame_end  = bit_end && (bit_cnt == 6'(LAST_BIT));
    // Word select leads the data by one slot, so it flips in slots 23 and 47.
    assign ws_next    = (bit_cnt >= 6'd23) && (bit_cnt < 6'(LAST_BIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_buf <= '0;
        end else if (tick_in) begin
            in_buf <= {audio0_in, audio1_in};
        end
    end

    // Outputs are registered from the counter position seen at the edge, so
    // the MSB of the buffer is already on sdo_out in the first slot-0 cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_last <= 3'd0;
            div_cnt  <= 3'd0;
            bit_cnt  <= 6'd0;
            frame_sr <= '0;
            req_out  <= 1'b0;
            sck_out  <= 1'b0;
            ws_out   <= 1'b0;
            sdo_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_out <= 1'b0;
                    sck_out <= 1'b0;
                    ws_out  <= 1'b0;
                    sdo_out <= 1'b0;
                    div_cnt <= 3'd0;
                    bit_cnt <= 6'd0;
                    if (play_in) begin
                        div_last <= i2s_div_last(cfg_in);
                        state    <= PLAY;
                    end
                end
                PLAY, STOPPING: begin
                    req_out <= frame_load;
                    sck_out <= (div_cnt > (div_last >> 1));
                    if (bit_start) begin
                        ws_out <= ws_next;
                        if (frame_load) begin
                            frame_sr <= in_buf[46:0];
                            sdo_out  <= in_buf[47];
                        end else begin
                            frame_sr <= {frame_sr[45:0], 1'b0};
                            sdo_out  <= frame_sr[46];
                        end
                    end
                    if (bit_end) begin
                        div_cnt <= 3'd0;
                        bit_cnt <= frame_end ? 6'd0 : bit_cnt + 6'd1;
                    end else begin
                        div_cnt <= div_cnt + 3'd1;
                    end
                    // A stop only takes effect at a frame boundary; the IDLE
                    // branch then zeroes the pins on the following cycle.
                    if (frame_end) begin
                        state <= play_in ? PLAY : IDLE;
                    end else begin
                        state <= play_in ? PLAY : STOPPING;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_unit.sv
// Scoreboard bench for i2s_unit: a frame-level model predicts every frame load,
// a monitor decodes the serial pins and compares each decoded frame.
module tb_i2s_unit;

    localparam logic [1:0] R48  = 2'b00;
    localparam logic [1:0] R96  = 2'b01;
    localparam logic [1:0] R192 = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        play_in = 1'b0;
    logic [1:0]  cfg_in = 2'b00;
    logic        tick_in = 1'b0;
    logic [23:0] audio0_in = '0;
    logic [23:0] audio1_in = '0;
    logic        req_out;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idle_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i2s_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play_in   (play_in),
        .cfg_in    (cfg_in),
        .tick_in   (tick_in),
        .audio0_in (audio0_in),
        .audio1_in (audio1_in),
        .req_out   (req_out),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .sdo_out   (sdo_out)
    );

    typedef struct {
        logic [47:0] frame;
        int          d;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Frame-level reference: a frame is a 48*D cycle window; it starts one
    // edge after play is seen in idle and repeats while play is high at its last edge.
    bit          m_active = 1'b0;
    int          m_load = 0;
    int          m_d = 8;
    logic [47:0] m_buf = '0;

    function automatic int rateDiv(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [47:0] wsMask();
        logic [47:0] m;
        m = '0;
        for (int p = 23; p <= 46; p++) m[p] = 1'b1;
        return m;
    endfunction

    function void modelEdge(input int e);
        exp_t x;
        if (m_active) begin
            if (e == m_load) begin
                x.frame = m_buf;
                x.d     = m_d;
                x.cyc   = e;
                exp_q.push_back(x);
            end
            if (e == m_load + 48 * m_d - 1) begin
                if (play_in) m_load = e + 1;
                else         m_active = 1'b0;
            end
        end else if (play_in) begin
            m_active = 1'b1;
            m_load   = e + 1;
            m_d      = rateDiv(cfg_in);
        end
        if (tick_in) m_buf = {audio0_in, audio1_in};
    endfunction

    function void modelReset();
        m_active = 1'b0;
        m_buf    = '0;
        exp_q.delete();
    endfunction

    function void checkValue(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    task automatic checkOutput(input string name, input logic req, input logic sck,
                               input logic ws, input logic sdo);
        checkValue(name, 48'({req_out, sck_out, ws_out, sdo_out}), 48'({req, sck, ws, sdo}));
    endtask

    task automatic applyStimulus(input logic play, input logic [1:0] cfg, input logic tick,
                                 input logic [23:0] a0, input logic [23:0] a1);
        @(negedge clk);
        play_in   = play;
        cfg_in    = cfg;
        tick_in   = tick;
        audio0_in = a0;
        audio1_in = a1;
        if (rst_n) modelEdge(cyc + 1);
        else       modelReset();
    endtask

    task automatic runCycles(input int n, input logic play, input logic [1:0] cfg, input bit ticks);
        for (int i = 0; i < n; i++) begin
            if (ticks && $urandom_range(0, 15) == 0)
                applyStimulus(play, cfg, 1'b1, 24'($urandom()), 24'($urandom()));
            else
                applyStimulus(play, cfg, 1'b0, audio0_in, audio1_in);
        end
    endtask

    // Advance until the next applyStimulus lands on the edge that opens the given slot.
    task automatic runToSlot(input int slot, input logic play, input logic [1:0] cfg);
        int guard;
        guard = 0;
        while (!(m_active && (m_load + slot * m_d == cyc + 2)) && guard < 2000) begin
            applyStimulus(play, cfg, 1'b0, audio0_in, audio1_in);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL slot_wait got timeout expected slot %0d", slot);
        end
    endtask

    task automatic stopAndIdle(input logic [1:0] cfg, input string name);
        applyStimulus(1'b0, cfg, 1'b0, audio0_in, audio1_in);
        runCycles(400, 1'b0, cfg, 1'b0);
        checkOutput(name, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: decodes sdo/ws at mid-bit (sck high) and checks the clock shape.
    bit          mon_active = 1'b0;
    int          mon_start, mon_d, mon_off, mon_slot, mon_ph, mon_err;
    logic [47:0] mon_frame, mon_got, mon_ws;
    exp_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (req_out && !mon_active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req got pulse expected none at cycle %0d", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    checkValue("req_time", 48'(cyc), 48'(cur.cyc));
                    mon_active = 1'b1;
                    mon_start  = cyc;
                    mon_d      = cur.d;
                    mon_frame  = cur.frame;
                    mon_got    = '0;
                    mon_ws     = '0;
                    mon_err    = 0;
                end
            end
            if (mon_active) begin
                mon_off  = cyc - mon_start;
                mon_slot = mon_off / mon_d;
                mon_ph   = mon_off % mon_d;
                if (sck_out !== (mon_ph >= mon_d / 2)) mon_err++;
                if (req_out !== (mon_off == 0)) mon_err++;
                if (mon_ph == mon_d / 2) begin
                    mon_got[47 - mon_slot] = sdo_out;
                    mon_ws[mon_slot]       = ws_out;
                end
                if (mon_off == 48 * mon_d - 1) begin
                    checkValue("left_sample", 48'(mon_got[47:24]), 48'(mon_frame[47:24]));
                    checkValue("right_sample", 48'(mon_got[23:0]), 48'(mon_frame[23:0]));
                    checkValue("ws_pattern", mon_ws, wsMask());
                    checkValue($sformatf("clock_pattern_d%0d", mon_d), 48'(mon_err), 48'd0);
                    mon_active = 1'b0;
                end
            end else if (sck_out || ws_out || sdo_out || req_out) begin
                idle_err++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] rc;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        $display("[TB] idle with play low");
        runCycles(1000, 1'b0, R48, 1'b0);
        checkOutput("idle_1000", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] 48 kHz directed frames");
        applyStimulus(1'b0, R48, 1'b1, 24'hA5A5A5, 24'h5A5A5A);
        applyStimulus(1'b1, R48, 1'b0, audio0_in, audio1_in);
        runCycles(400, 1'b1, R48, 1'b0);
        runToSlot(10, 1'b1, R48);
        stopAndIdle(R48, "stop_48k_idle");

        $display("[TB] 192 kHz directed frame");
        applyStimulus(1'b0, R192, 1'b1, 24'h800001, 24'h7FFFFF);
        applyStimulus(1'b1, R192, 1'b0, audio0_in, audio1_in);
        runToSlot(10, 1'b1, R192);
        stopAndIdle(R192, "stop_192k_idle");

        $display("[TB] drop and re-raise play");
        applyStimulus(1'b1, R48, 1'b1, 24'($urandom()), 24'($urandom()));
        runToSlot(10, 1'b1, R48);
        applyStimulus(1'b0, R48, 1'b0, audio0_in, audio1_in);
        runToSlot(30, 1'b0, R48);
        applyStimulus(1'b1, R48, 1'b1, 24'($urandom()), 24'($urandom()));
        runToSlot(5, 1'b1, R48);
        stopAndIdle(R48, "rearm_idle");

        $display("[TB] rate change while playing");
        applyStimulus(1'b1, R48, 1'b1, 24'($urandom()), 24'($urandom()));
        runCycles(50, 1'b1, R96, 1'b1);
        runToSlot(10, 1'b1, R96);
        stopAndIdle(R96, "cfg_ignored_idle");
        applyStimulus(1'b1, R96, 1'b1, 24'($urandom()), 24'($urandom()));
        runCycles(200, 1'b1, R96, 1'b0);
        runToSlot(10, 1'b1, R96);
        stopAndIdle(R96, "cfg_restart_idle");

        $display("[TB] tick at frame load");
        applyStimulus(1'b1, R96, 1'b1, 24'($urandom()), 24'($urandom()));
        runCycles(20, 1'b1, R96, 1'b0);
        runToSlot(0, 1'b1, R96);
        applyStimulus(1'b1, R96, 1'b1, 24'($urandom()), 24'($urandom()));
        applyStimulus(1'b1, R96, 1'b1, 24'($urandom()), 24'($urandom()));
        runToSlot(10, 1'b1, R96);
        stopAndIdle(R96, "tick_load_idle");

        $display("[TB] randomized sessions");
        for (int s = 0; s < 4; s++) begin
            rc = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, rc, 1'b1, 24'($urandom()), 24'($urandom()));
            runCycles(48 * rateDiv(rc) * $urandom_range(1, 2), 1'b1, rc, 1'b1);
            runToSlot($urandom_range(1, 46), 1'b1, rc);
            applyStimulus(1'b0, rc, 1'b0, audio0_in, audio1_in);
            runCycles(400, 1'b0, rc, 1'b1);
        end

        $display("[TB] reset in mid-frame");
        applyStimulus(1'b1, R48, 1'b1, 24'($urandom()), 24'($urandom()));
        runToSlot(20, 1'b1, R48);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_midframe", 1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        play_in = 1'b0;
        tick_in = 1'b0;
        applyStimulus(1'b0, R48, 1'b1, 24'($urandom()), 24'($urandom()));
        applyStimulus(1'b1, R48, 1'b0, audio0_in, audio1_in);
        runToSlot(10, 1'b1, R48);
        stopAndIdle(R48, "after_reset_idle");

        runCycles(20, 1'b0, R48, 1'b0);
        checkValue("pending_frames", 48'(exp_q.size()), 48'd0);
        checkValue("idle_outputs", 48'(idle_err), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
